if_insn_queue: RTL and testbench

//  Instruction prefetch queue placed directly downstream of the IF stage's
//  IF/ID register. It captures each new if_pc/if_insn/if_en word and holds it
//  in a small FIFO. It then presents the head entry to the ID stage.

---
 rtl/if_insn_queue.sv | 60 ++++++
 tb/tb_if_insn_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/if_insn_queue.sv
// if_insn_queue: prefetch FIFO between the IF/ID register and ID, letting IF run ahead while ID stalls.
module if_insn_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [29:0]      if_pc,
    input  logic [31:0]      if_insn,
    input  logic             if_en,
    input  logic             if_stall,
    input  logic             flush,
    input  logic             id_stall,
    output logic [29:0]      q_pc,
    output logic [31:0]      q_insn,
    output logic             q_en,
    output logic             q_stall,
    output logic [PTR_W:0]   q_count,
    output logic             q_ovf
);
    logic [61:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             fresh, push, pop, full, wr;

    assign full    = count == (PTR_W+1)'(DEPTH);
    assign q_en    = count != '0;
    assign push    = fresh & if_en & ~flush;
    assign pop     = q_en & ~id_stall & ~flush;
    // a push into a full queue only lands if a slot frees on the same edge
    assign wr      = push & (~full | pop);
    assign q_stall = count >= (PTR_W+1)'(DEPTH-1);
    assign q_count = count;
    assign q_pc    = q_en ? mem[rd_ptr][61:32] : '0;
    assign q_insn  = q_en ? mem[rd_ptr][31:0]  : '0;

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= {if_pc, if_insn};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fresh  <= 1'b0;
            q_ovf  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fresh  <= 1'b0;
        end else begin
            fresh <= ~if_stall;
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= (wr & ~pop) ? count + 1'b1 : (pop & ~wr) ? count - 1'b1 : count;
            if (push & ~wr) q_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_insn_queue.sv
// tb_if_insn_queue: directed checks of the instruction prefetch queue.
module tb_if_insn_queue;
    logic        clk = 1'b0, rst = 1'b0;
    logic [29:0] if_pc = '0;
    logic [31:0] if_insn = '0;
    logic        if_en = 1'b0, if_stall = 1'b1, flush = 1'b0, id_stall = 1'b0;
    logic [29:0] q_pc;
    logic [31:0] q_insn;
    logic        q_en, q_stall, q_ovf;
    logic [2:0]  q_count;
    int          errors = 0, checks = 0;

    if_insn_queue dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en),
        .if_stall(if_stall), .flush(flush), .id_stall(id_stall), .q_pc(q_pc),
        .q_insn(q_insn), .q_en(q_en), .q_stall(q_stall), .q_count(q_count), .q_ovf(q_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic word(input logic [29:0] pc);
        if_pc = pc;
        if_insn = 32'hA000_0000 | 32'(pc);
    endtask

    initial begin
        step();
        step();
        chk("rst_en", q_en, 0);
        chk("rst_pc", q_pc, 0);
        chk("rst_insn", q_insn, 0);
        chk("rst_stall", q_stall, 0);
        chk("rst_count", q_count, 0);
        chk("rst_ovf", q_ovf, 0);
        rst = 1'b1;
        // test 1: stream through with ID consuming
        if_stall = 1'b0;
        step();
        if_en = 1'b1;
        word(30'h10);
        step();
        chk("t1_pc0", q_pc, 30'h10);
        chk("t1_insn0", q_insn, 32'hA000_0010);
        chk("t1_cnt0", q_count, 1);
        word(30'h11);
        step();
        chk("t1_pc1", q_pc, 30'h11);
        chk("t1_cnt1", q_count, 1);
        word(30'h12);
        step();
        chk("t1_pc2", q_pc, 30'h12);
        chk("t1_cnt2", q_count, 1);
        if_en = 1'b0;
        step();
        chk("t1_empty", q_en, 0);
        chk("t1_ovf", q_ovf, 0);
        // test 2: ID stalls, IF throttled by q_stall
        id_stall = 1'b1;
        if_en = 1'b1;
        word(30'h20);
        step();
        word(30'h21);
        step();
        chk("t2_stall2", q_stall, 0);
        word(30'h22);
        step();
        chk("t2_cnt3", q_count, 3);
        chk("t2_stall3", q_stall, 1);
        word(30'h23);
        if_stall = 1'b1;
        step();
        chk("t2_cnt4", q_count, 4);
        chk("t2_head", q_pc, 30'h20);
        step();
        chk("t2_hold", q_count, 4);
        chk("t2_ovf", q_ovf, 0);
        // test 3: push and pop on the same edge while full, across the wrap
        if_stall = 1'b0;
        step();
        chk("t3_nopush", q_count, 4);
        word(30'h24);
        if_stall = 1'b1;
        id_stall = 1'b0;
        step();
        chk("t3_cnt", q_count, 4);
        chk("t3_pc21", q_pc, 30'h21);
        chk("t3_ovf", q_ovf, 0);
        step();
        chk("t3_pc22", q_pc, 30'h22);
        step();
        chk("t3_pc23", q_pc, 30'h23);
        step();
        chk("t3_pc24", q_pc, 30'h24);
        chk("t3_cnt1", q_count, 1);
        step();
        chk("t3_empty", q_count, 0);
        // test 4: held IF/ID word is captured once
        id_stall = 1'b1;
        if_en = 1'b0;
        if_stall = 1'b0;
        step();
        if_en = 1'b1;
        if_pc = 30'h30;
        if_insn = 32'hDEAD_BEEF;
        if_stall = 1'b1;
        step();
        step();
        step();
        chk("t4_cnt", q_count, 1);
        chk("t4_insn", q_insn, 32'hDEAD_BEEF);
        chk("t4_pc", q_pc, 30'h30);
        // test 5: flush discards queue and the in-flight word
        if_stall = 1'b0;
        word(30'h31);
        step();
        step();
        chk("t5_cnt2", q_count, 2);
        word(30'h32);
        step();
        chk("t5_cnt3", q_count, 3);
        word(30'h33);
        if_stall = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_cnt0", q_count, 0);
        chk("t5_en", q_en, 0);
        chk("t5_insn", q_insn, 0);
        chk("t5_pc", q_pc, 0);
        id_stall = 1'b0;
        step();
        chk("t5_notq", q_count, 0);
        // test 6: forced overflow drops the entry and sets a sticky flag
        id_stall = 1'b1;
        if_stall = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            word(30'h40 + 30'(i));
            step();
        end
        chk("t6_full", q_count, 4);
        chk("t6_ovf0", q_ovf, 0);
        word(30'h44);
        step();
        chk("t6_ovf1", q_ovf, 1);
        chk("t6_cnt", q_count, 4);
        chk("t6_head", q_pc, 30'h40);
        if_en = 1'b0;
        id_stall = 1'b0;
        step();
        chk("t6_pc41", q_pc, 30'h41);
        step();
        chk("t6_pc42", q_pc, 30'h42);
        step();
        chk("t6_pc43", q_pc, 30'h43);
        step();
        chk("t6_drop", q_en, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_sticky", q_ovf, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_ovf", q_ovf, 0);
        chk("t6_rst_cnt", q_count, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
